// File: rtl/seq_match_logger.sv
// seq_match_logger: timestamps detector matches into a small FIFO, drained over
// valid/ready, with saturating match count and sticky overflow status.
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Y,
    input  logic             EN,
    input  logic             CLR,
    input  logic             OUT_READY,
    output logic             OUT_VALID,
    output logic [TS_W-1:0]  OUT_DATA,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [AW:0]      FIFO_LEVEL,
    output logic             OVERFLOW
);
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level;
    logic            ev, pop, full, drop, push;

    assign ev         = Y & EN;
    assign pop        = OUT_VALID & OUT_READY;
    assign full       = level == (AW+1)'(DEPTH);
    assign drop       = ev & full & ~pop;
    assign push       = ev & ~drop;
    assign OUT_VALID  = level != '0;
    assign FIFO_LEVEL = level;

    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= ts;

    // OUT_DATA mirrors the head slot; on pop it reloads from the next slot, or
    // from the incoming timestamp when that entry becomes the only one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            OUT_DATA  <= '0;
            MATCH_CNT <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= (push && !pop) ? level + (AW+1)'(1) :
                     (pop && !push) ? level - (AW+1)'(1) : level;
            if (push && (level == '0 || (pop && level == (AW+1)'(1))))
                OUT_DATA <= ts;
            else if (pop && level > (AW+1)'(1))
                OUT_DATA <= mem[rd_ptr + AW'(1)];
            MATCH_CNT <= CLR ? CNT_W'(ev) :
                         (ev && MATCH_CNT != '1) ? MATCH_CNT + CNT_W'(1) : MATCH_CNT;
            OVERFLOW  <= drop | (OVERFLOW & ~CLR);
        end
    end
endmodule

// File: tb/tb_seq_match_logger.sv
// tb_seq_match_logger: directed checks of logging, FIFO full/drain, CLR, saturation and TS wrap.
module tb_seq_match_logger;
    logic        CLK = 0, RST = 1, Y = 0, Y4 = 0, EN = 1, CLR = 0, OUT_READY = 0;
    logic        v, ovf, v4, ovf4;
    logic [15:0] d;
    logic [3:0]  d4;
    logic [7:0]  cnt, cnt4;
    logic [2:0]  lvl, lvl4;
    int          n_cmp = 0, n_err = 0, ts = 0;
    int          q[$];
    int          drain_exp[$] = '{2, 3, 4, 7};

    seq_match_logger u1 (
        .CLK(CLK), .RST(RST), .Y(Y), .EN(EN), .CLR(CLR), .OUT_READY(OUT_READY),
        .OUT_VALID(v), .OUT_DATA(d), .MATCH_CNT(cnt), .FIFO_LEVEL(lvl), .OVERFLOW(ovf)
    );
    seq_match_logger #(.TS_W(4)) u4 (
        .CLK(CLK), .RST(RST), .Y(Y4), .EN(EN), .CLR(CLR), .OUT_READY(OUT_READY),
        .OUT_VALID(v4), .OUT_DATA(d4), .MATCH_CNT(cnt4), .FIFO_LEVEL(lvl4), .OVERFLOW(ovf4)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
        ts = RST ? 0 : ts + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_all;
        RST = 1; Y = 0; Y4 = 0; EN = 1; CLR = 0; OUT_READY = 0;
        tick;
        RST = 0;
    endtask

    initial begin
        reset_all;
        chk("rst_valid", v, 0);
        chk("rst_data", d, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_level", lvl, 0);
        chk("rst_ovf", ovf, 0);

        repeat (5) tick;
        Y = 1; tick; Y = 0;
        chk("t1_valid", v, 1);
        chk("t1_data", d, 5);
        chk("t1_level", lvl, 1);
        chk("t1_cnt", cnt, 1);

        reset_all;
        for (int i = 0; i < 10; i++) begin
            Y = (i == 2 || i == 3 || i == 4 || i == 7 || i == 9);
            tick;
            if (i == 7) begin
                chk("t2_level_full", lvl, 4);
                chk("t2_ovf_before", ovf, 0);
                chk("t2_cnt4", cnt, 4);
            end
        end
        Y = 0;
        chk("t2_ovf", ovf, 1);
        chk("t2_cnt5", cnt, 5);
        chk("t2_level", lvl, 4);
        OUT_READY = 1;
        foreach (drain_exp[i]) begin
            chk("t2_drain_valid", v, 1);
            chk("t2_drain_data", d, drain_exp[i]);
            tick;
        end
        chk("t2_empty_valid", v, 0);
        chk("t2_empty_level", lvl, 0);

        reset_all;
        q.delete();
        repeat (4) begin q.push_back(ts); Y = 1; tick; end
        OUT_READY = 1;
        q.push_back(ts);
        tick;
        Y = 0;
        chk("t3_level", lvl, 4);
        chk("t3_ovf", ovf, 0);
        void'(q.pop_front());
        foreach (q[i]) begin
            chk("t3_drain_data", d, q[i]);
            tick;
        end
        chk("t3_empty", v, 0);

        reset_all;
        Y = 1;
        repeat (5) tick;
        chk("t4_cnt_pre", cnt, 5);
        chk("t4_ovf_pre", ovf, 1);
        CLR = 1;
        tick;
        chk("t4_clr_ev_cnt", cnt, 1);
        chk("t4_clr_drop_ovf", ovf, 1);
        Y = 0;
        tick;
        CLR = 0;
        chk("t4_clr_cnt", cnt, 0);
        chk("t4_clr_ovf", ovf, 0);
        chk("t4_level", lvl, 4);
        chk("t4_data", d, 0);

        EN = 0; Y = 1;
        repeat (10) tick;
        chk("t5_en0_cnt", cnt, 0);
        chk("t5_en0_level", lvl, 4);
        EN = 1; OUT_READY = 1;
        repeat (255) tick;
        chk("t5_cnt255", cnt, 255);
        repeat (45) tick;
        Y = 0;
        chk("t5_sat", cnt, 255);
        chk("t5_ovf", ovf, 0);
        chk("t5_level", lvl, 4);

        reset_all;
        while (ts % 16 != 15) tick;
        Y4 = 1; tick; tick;
        Y4 = 0;
        chk("t6_head15", d4, 15);
        chk("t6_level2", lvl4, 2);
        OUT_READY = 1; tick; OUT_READY = 0;
        chk("t6_wrap0", d4, 0);
        chk("t6_level1", lvl4, 1);
        Y4 = 1; tick; tick; Y4 = 0;
        chk("t6_level3", lvl4, 3);
        RST = 1; tick; RST = 0;
        chk("t6_rst_level", lvl4, 0);
        chk("t6_rst_valid", v4, 0);
        tick;
        Y4 = 1; tick; Y4 = 0;
        chk("t6_ts_restart", d4, 1);
        chk("t6_level_after", lvl4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
